// File: rtl/joy_serial_multi_if.sv
// Chain and publish signals of the serial joystick reader.
// master = reader side, slave = chain/core side.
interface joy_serial_multi_if #(
    parameter int PLAYERS = 2
);
    logic                    enable;
    logic                    joy_data;
    logic                    joy_clk;
    logic                    joy_load;
    logic [PLAYERS*16-1:0]   joystick;
    logic                    frame_done;

    modport master (
        input  enable,
        input  joy_data,
        output joy_clk,
        output joy_load,
        output joystick,
        output frame_done
    );

    modport slave (
        output enable,
        output joy_data,
        input  joy_clk,
        input  joy_load,
        input  joystick,
        input  frame_done
    );
endinterface

// File: rtl/joy_serial_multi.sv
// Reads PLAYERS x BITS buttons from a 74HC165-style chain every frame and
// publishes them as zero-extended 16-bit words, with optional debounce.
module joy_serial_multi #(
    parameter int PLAYERS    = 2,
    parameter int BITS       = 12,
    parameter int CLK_DIV    = 24,
    parameter int GAP        = 64,
    parameter int ACTIVE_LOW = 1,
    parameter int DEBOUNCE   = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    joy_serial_multi_if.master joy
);
    localparam int NB     = PLAYERS * BITS;
    localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int WAIT_W = $clog2(GAP + 1);
    localparam int JW     = PLAYERS * 16;

    typedef enum logic [2:0] {IDLE, LOAD, SAMPLE, SHIFT, UPDATE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [NB-1:0]       shift_q, shift_d;
    logic [NB-1:0]       prev_q, prev_d;
    logic [JW-1:0]       joystick_q, joystick_d;
    logic                joy_clk_q, joy_clk_d;
    logic                joy_load_q, joy_load_d;
    logic                frame_done_q, frame_done_d;
    logic                sync1_q, sync2_q;
    logic                tick;
    logic                data_bit;

    function automatic logic [JW-1:0] pack_words(input logic [NB-1:0] bits);
        logic [JW-1:0] w;
        w = '0;
        for (int p = 0; p < PLAYERS; p++)
            w[p*16 +: 16] = 16'(bits[p*BITS +: BITS]);
        return w;
    endfunction

    assign tick     = joy.enable && (div_q == DIV_W'(CLK_DIV - 1));
    assign data_bit = sync2_q ^ (ACTIVE_LOW != 0);

    always_comb begin
        state_d      = state_q;
        div_d        = tick ? '0 : div_q + DIV_W'(1);
        bitcnt_d     = bitcnt_q;
        wait_d       = wait_q;
        shift_d      = shift_q;
        prev_d       = prev_q;
        joystick_d   = joystick_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) state_d = LOAD;
            end
            LOAD: begin
                if (tick) begin
                    bitcnt_d = '0;
                    state_d  = SAMPLE;
                end
            end
            SAMPLE: begin
                if (tick) begin
                    shift_d[bitcnt_q] = data_bit;
                    state_d = (bitcnt_q == CNT_W'(NB - 1)) ? UPDATE : SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    state_d  = SAMPLE;
                end
            end
            UPDATE: begin
                // Divider pauses here so the frame gains exactly one clk.
                div_d        = div_q;
                frame_done_d = 1'b1;
                if (DEBOUNCE == 0 || shift_q == prev_q)
                    joystick_d = pack_words(shift_q);
                prev_d  = shift_q;
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // One trailing tick closes the last bit cell, then GAP idle ticks.
                if (tick) begin
                    if (wait_q == WAIT_W'(GAP)) state_d = LOAD;
                    else                        wait_d  = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (!joy.enable) begin
            state_d      = IDLE;
            div_d        = '0;
            bitcnt_d     = '0;
            wait_d       = '0;
            shift_d      = '0;
            prev_d       = '0;
            joystick_d   = '0;
            frame_done_d = 1'b0;
        end

        joy_clk_d  = (state_d == SHIFT);
        joy_load_d = (state_d != LOAD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bitcnt_q     <= '0;
            wait_q       <= '0;
            shift_q      <= '0;
            prev_q       <= '0;
            joystick_q   <= '0;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            frame_done_q <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bitcnt_q     <= bitcnt_d;
            wait_q       <= wait_d;
            shift_q      <= shift_d;
            prev_q       <= prev_d;
            joystick_q   <= joystick_d;
            joy_clk_q    <= joy_clk_d;
            joy_load_q   <= joy_load_d;
            frame_done_q <= frame_done_d;
            sync1_q      <= joy.joy_data;
            sync2_q      <= sync1_q;
        end
    end

    assign joy.joy_clk    = joy_clk_q;
    assign joy.joy_load   = joy_load_q;
    assign joy.joystick   = joystick_q;
    assign joy.frame_done = frame_done_q;
endmodule

// File: tb/tb_joy_serial_multi.sv
// Directed bench for joy_serial_multi: four instances with behavioural
// 74HC165 chain models and hand-computed expected joystick words.
module tb_joy_serial_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    logic rst3_n = 1'b0;

    joy_serial_multi_if #(.PLAYERS(2)) if0 ();
    joy_serial_multi_if #(.PLAYERS(2)) if1 ();
    joy_serial_multi_if #(.PLAYERS(2)) if2 ();
    joy_serial_multi_if #(.PLAYERS(4)) if3 ();

    joy_serial_multi #(.PLAYERS(2), .BITS(12), .CLK_DIV(24), .GAP(64),
                       .ACTIVE_LOW(1), .DEBOUNCE(1))
        u_def (.clk(clk), .reset_n(rst0_n), .joy(if0));

    joy_serial_multi #(.PLAYERS(2), .BITS(12), .CLK_DIV(4), .GAP(2),
                       .ACTIVE_LOW(1), .DEBOUNCE(1))
        u_db1 (.clk(clk), .reset_n(rst1_n), .joy(if1));

    joy_serial_multi #(.PLAYERS(2), .BITS(12), .CLK_DIV(4), .GAP(2),
                       .ACTIVE_LOW(1), .DEBOUNCE(0))
        u_db0 (.clk(clk), .reset_n(rst1_n), .joy(if2));

    joy_serial_multi #(.PLAYERS(4), .BITS(16), .CLK_DIV(2), .GAP(1),
                       .ACTIVE_LOW(0), .DEBOUNCE(0))
        u_wide (.clk(clk), .reset_n(rst3_n), .joy(if3));

    // Chain models: bit i of wireN is the level shifted out i-th after a load.
    logic [63:0] wire0 = 64'd0;
    logic [63:0] wire1 = 64'd0;
    logic [63:0] wire3 = 64'd0;
    int idx0 = 0;
    int idx1 = 0;
    int idx3 = 0;

    always @(negedge if0.joy_load or posedge if0.joy_clk)
        if (!if0.joy_load) idx0 <= 0; else if (idx0 < 63) idx0 <= idx0 + 1;
    always @(negedge if1.joy_load or posedge if1.joy_clk)
        if (!if1.joy_load) idx1 <= 0; else if (idx1 < 63) idx1 <= idx1 + 1;
    always @(negedge if3.joy_load or posedge if3.joy_clk)
        if (!if3.joy_load) idx3 <= 0; else if (idx3 < 63) idx3 <= idx3 + 1;

    assign if0.joy_data = wire0[idx0];
    assign if1.joy_data = wire1[idx1];
    assign if2.joy_data = wire1[idx1];
    assign if3.joy_data = wire3[idx3];

    int fd_cnt0 = 0;
    always @(posedge clk) if (if0.frame_done) fd_cnt0 <= fd_cnt0 + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // kind: 0 frame_done high, 1 joy_load low, 2 joy_clk high, 3 joy_clk low
    function automatic logic sig(input int which, input int kind);
        logic fd, ld, jc;
        case (which)
            0:       begin fd = if0.frame_done; ld = if0.joy_load; jc = if0.joy_clk; end
            1:       begin fd = if1.frame_done; ld = if1.joy_load; jc = if1.joy_clk; end
            default: begin fd = if3.frame_done; ld = if3.joy_load; jc = if3.joy_clk; end
        endcase
        case (kind)
            0:       return fd;
            1:       return !ld;
            2:       return jc;
            default: return !jc;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input int kind,
                            input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!sig(which, kind) && n < budget);
        check_eq({tag, "_seen"}, 64'(sig(which, kind)), 64'd1);
    endtask

    logic [23:0] pat    [6] = '{24'h0, 24'h0, 24'h8, 24'h0, 24'h20, 24'h20};
    logic [31:0] exp_db0[6] = '{32'h0, 32'h0, 32'h8, 32'h0, 32'h20, 32'h20};
    logic [31:0] exp_db1[6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h20};

    initial begin
        int n;
        int saved;
        if0.enable = 1'b0;
        if1.enable = 1'b0;
        if2.enable = 1'b0;
        if3.enable = 1'b0;
        // Buttons p0=0A5, p1=F0F driven active-low on the wire.
        wire0 = 64'h0000_0000_000F_0F5A;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_joy_clk",    64'(if0.joy_clk),    64'd0);
        check_eq("rst_joy_load",   64'(if0.joy_load),   64'd1);
        check_eq("rst_joystick",   64'(if0.joystick),   64'd0);
        check_eq("rst_frame_done", 64'(if0.frame_done), 64'd0);

        @(negedge clk);
        if0.enable = 1'b1;
        rst0_n     = 1'b1;
        wait_sig("first_load", 0, 1, 100, n);
        check_eq("first_load_clks", 64'(n), 64'd24);

        wait_sig("fd1", 0, 0, 4000, n);
        check_eq("f1_joystick_debounced", 64'(if0.joystick), 64'd0);
        @(posedge clk); #1;
        check_eq("fd_width", 64'(if0.frame_done), 64'd0);
        wait_sig("fd2", 0, 0, 4000, n);
        check_eq("period_f2", 64'(n + 1), 64'd2713);
        check_eq("f2_joystick", 64'(if0.joystick), 64'h0F0F_00A5);
        @(posedge clk); #1;
        wait_sig("fd3", 0, 0, 4000, n);
        check_eq("period_f3", 64'(n + 1), 64'd2713);
        check_eq("f3_joystick", 64'(if0.joystick), 64'h0F0F_00A5);

        // Drop enable after 10 captured bits.
        wait_sig("b_load", 0, 1, 4000, n);
        for (int b = 0; b < 10; b++) begin
            wait_sig("b_clk_hi", 0, 2, 200, n);
            wait_sig("b_clk_lo", 0, 3, 200, n);
        end
        saved = fd_cnt0;
        @(negedge clk);
        if0.enable = 1'b0;
        @(posedge clk); #1;
        check_eq("dis_joystick", 64'(if0.joystick), 64'd0);
        check_eq("dis_joy_load", 64'(if0.joy_load), 64'd1);
        check_eq("dis_joy_clk",  64'(if0.joy_clk),  64'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        if0.enable = 1'b1;
        wait_sig("reen_load", 0, 1, 100, n);
        check_eq("reen_load_clks", 64'(n), 64'd24);
        check_eq("no_partial_fd", 64'(fd_cnt0), 64'(saved));
        wait_sig("reen_fd1", 0, 0, 4000, n);
        @(posedge clk); #1;
        wait_sig("reen_fd2", 0, 0, 4000, n);
        check_eq("reen_joystick", 64'(if0.joystick), 64'h0F0F_00A5);

        // Asynchronous reset while joy_clk is high.
        wait_sig("mid_shift", 0, 2, 3000, n);
        #2 rst0_n = 1'b0;
        #1;
        check_eq("arst_joy_clk",  64'(if0.joy_clk),  64'd0);
        check_eq("arst_joy_load", 64'(if0.joy_load), 64'd1);
        check_eq("arst_joystick", 64'(if0.joystick), 64'd0);
        @(negedge clk);
        rst0_n = 1'b1;
        wait_sig("arst_load", 0, 1, 100, n);
        check_eq("arst_load_clks", 64'(n), 64'd24);

        // Debounce on/off with a single-frame glitch on player 0 bit 3.
        wire1 = {40'd0, ~pat[0]};
        @(negedge clk);
        rst1_n     = 1'b1;
        if1.enable = 1'b1;
        if2.enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_sig($sformatf("db_fd%0d", k), 1, 0, 1000, n);
            check_eq($sformatf("db1_f%0d", k), 64'(if1.joystick), 64'(exp_db1[k]));
            check_eq($sformatf("db0_f%0d", k), 64'(if2.joystick), 64'(exp_db0[k]));
            if (k < 5) wire1 = {40'd0, ~pat[k + 1]};
        end

        // Walking one across 4 players x 16 bits, active-high wire.
        wire3 = 64'd1;
        @(negedge clk);
        rst3_n     = 1'b1;
        if3.enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wait_sig($sformatf("walk_fd%0d", i), 3, 0, 1000, n);
            check_eq($sformatf("walk%0d", i), 64'(if3.joystick), 64'd1 << i);
            if (i < 63) wire3 = 64'd1 << (i + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
